frame_sync: RTL
===============

Name: frame_sync

Overview:
- Bit-level frame synchronizer placed directly downstream of the bit synchronizer in the demodulator receive chain.
- Samples the demodulated serial data on each rising edge of the recovered bit-sync square wave.
- Searches for a 16-bit unique word (UW) with error tolerance, then confirms lock with a SEARCH/VERIFY/LOCK flywheel.
- Once locked, delivers frame payload as bytes to the downstream deframer.

Parameters:
UW, 16'hEB90, unique word pattern; the MSB is received first
UW_LEN, 16, unique word length in bits
FRAME_LEN, 256, frame length in bits, UW included; (FRAME_LEN-UW_LEN) must be a multiple of 8
ERR_TH, 1, maximum Hamming distance accepted as a UW match
VERIFY_N, 2, consecutive UW hits required to declare lock, the first hit included
MISS_N, 3, consecutive UW misses in LOCK that force a return to SEARCH

Ports:
clk  input  1  system clock, 32 MHz
rst  input  1  asynchronous, active-low reset
sync  input  1  bit-sync square wave from the bit synchronizer; asynchronous to data content, one period per bit
datain  input  1  demodulated serial data, stable around the rising edge of sync
dout  output  8  payload byte, first-received bit in dout[7]
dout_vld  output  1  one-clk strobe, dout valid
frame_start  output  1  one-clk strobe on every UW accepted while in LOCK or on entry to LOCK
locked  output  1  high while in LOCK
state  output  2  00 SEARCH, 01 VERIFY, 10 LOCK
uw_inv  output  1  polarity flag, see Optional Feature; tied to 0 when the feature is compiled out

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=SEARCH, shift register and all counters cleared. Reset mid-frame discards any partial byte.
- Input conditioning: sync and datain each pass through two flops. bit_en is high for one clk when the synced sync is 1 and its previous value was 0. The sampled bit is the twice-registered datain.
- On each bit_en: sr <= {sr[UW_LEN-2:0], bit}. dist = popcount(sr_next ^ UW), computed combinationally on the updated register value. match = (dist <= ERR_TH).
- Bit counter cnt, width clog2(FRAME_LEN):
  - Cleared to 0 on the bit that completes an accepted UW.
  - Otherwise increments on each bit_en and wraps from FRAME_LEN-1 to 0.
  - The UW window is checked on the bit where cnt==FRAME_LEN-1.
- SEARCH:
  - Every bit is tested.
  - On match: go to VERIFY, hit=1, cnt=0.
  - hit==VERIFY_N is tested on entry, so VERIFY_N=1 goes directly to LOCK.
- VERIFY (only the window bit is tested):
  - match: hit+1; when hit reaches VERIFY_N, go to LOCK, miss=0, pulse frame_start.
  - mismatch: go to SEARCH. The same bit is not re-tested.
- LOCK (only the window bit is tested):
  - match: miss=0, pulse frame_start.
  - mismatch: miss+1; when miss reaches MISS_N, go to SEARCH, otherwise stay in LOCK (flywheel).
  - The window position never re-aligns while in LOCK.
- Payload output (LOCK only):
  - Payload bits are those with cnt after update in 1..FRAME_LEN-UW_LEN.
  - They are shifted into a byte register, MSB first.
  - On the 8th bit: dout updates and dout_vld pulses for 1 clk.
  - Exactly (FRAME_LEN-UW_LEN)/8 strobes per frame; 30 with the default parameters.
  - UW bits are never output.
  - Frames that end in a miss still emit payload.
- Leaving LOCK clears the byte register and the bit counter.
- Latency: dout_vld and frame_start assert 3 clk after the sync rising edge at the port that carries the deciding bit. dout holds its value until the next strobe.
- Simultaneous events: the state transition and frame_start are evaluated on the same bit_en. No payload byte completes on the window bit.

Optional Feature:
- Macro: FRAME_SYNC_INV_DETECT_EN.
- When defined:
  - SEARCH also accepts the inverted UW (popcount(sr_next ^ ~UW) <= ERR_TH); normal polarity has priority if both match.
  - uw_inv latches 1 on an inverted match and 0 on a normal match.
  - VERIFY and LOCK compare against the latched polarity only.
  - Payload bits are XORed with uw_inv before output. This resolves the 180° PSK phase ambiguity.
- When undefined: normal polarity only, uw_inv constant 0, no inversion logic.

Test Plan:
- Reset: rst low mid-stream, asynchronous → all outputs 0 within the same clk, state=00, no dout_vld until relock.
- Clean lock: sync period 64 clk, frames with UW=EB90 and payload bytes 00,01,…,1D → state 00→01 after the first UW, 10 after the second UW. frame_start pulses, then 30 dout_vld strobes per frame carrying 00..1D in order, locked=1.
- Error tolerance: 1 bit flipped in the UW of frame 3 → still a match, no miss. 2 bits flipped → miss=1, stays LOCK, payload still output.
- Loss of lock: 3 consecutive frames with UW=0000 after lock → state returns to 00 on the 3rd window bit, locked=0, dout_vld stops.
- False sync: EB90 embedded in the payload of the first frame, while in SEARCH → enters VERIFY, next window mismatches, back to SEARCH, then locks on the true UW.
- Inverted stream, FRAME_SYNC_INV_DETECT_EN defined: all bits inverted → lock after 2 frames, uw_inv=1, dout recovers 00..1D. With the macro undefined, the same stimulus never leaves SEARCH.

Source files
------------

// File: rtl/frame_sync_if.sv
// Bit-sync/data inputs and byte/status outputs of the frame synchronizer.
// The slave modport is the synchronizer side, the master modport drives the bit stream.
interface frame_sync_if;
    logic       sync;
    logic       datain;
    logic [7:0] dout;
    logic       dout_vld;
    logic       frame_start;
    logic       locked;
    logic [1:0] state;
    logic       uw_inv;

    modport master (
        output sync, datain,
        input  dout, dout_vld, frame_start, locked, state, uw_inv
    );

    modport slave (
        input  sync, datain,
        output dout, dout_vld, frame_start, locked, state, uw_inv
    );
endinterface

// File: rtl/frame_sync.sv
// Bit-level frame synchronizer: error-tolerant unique-word search, SEARCH/VERIFY/LOCK flywheel, byte output.
// Define FRAME_SYNC_INV_DETECT_EN to also accept the inverted unique word and de-invert the payload.
module frame_sync #(
    parameter int                UW_LEN    = 16,
    parameter logic [UW_LEN-1:0] UW        = 16'hEB90,
    parameter int                FRAME_LEN = 256,
    parameter int                ERR_TH    = 1,
    parameter int                VERIFY_N  = 2,
    parameter int                MISS_N    = 3
) (
    input  logic        clk,
    input  logic        rst,
    frame_sync_if.slave bus
);
    localparam int CNT_W   = $clog2(FRAME_LEN);
    localparam int DIST_W  = $clog2(UW_LEN + 1);
    localparam int HIT_W   = $clog2(VERIFY_N + 1);
    localparam int MISS_W  = $clog2(MISS_N + 1);
    localparam int PAY_LEN = FRAME_LEN - UW_LEN;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  PAY_LAST = CNT_W'(PAY_LEN);
    localparam logic [DIST_W-1:0] ERR_LIM  = DIST_W'(ERR_TH);

    typedef enum logic [1:0] {SEARCH = 2'b00, VERIFY = 2'b01, LOCK = 2'b10} state_t;

    function automatic logic [DIST_W-1:0] popCount(input logic [UW_LEN-1:0] v);
        logic [DIST_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < UW_LEN; i++) acc = acc + DIST_W'(v[i]);
        return acc;
    endfunction

    logic [2:0]        syncPipe_q;
    logic [1:0]        dataPipe_q;
    state_t            state_q, state_d;
    logic [UW_LEN-2:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [6:0]        byte_q, byte_d;
    logic [7:0]        dout_q, dout_d;
    logic              doutVld_q, doutVld_d;
    logic              frameStart_q, frameStart_d;

    logic              bitEn, rxBit, window, matchNorm;
    logic              searchHit, windowHit, payBit;
    logic [UW_LEN-1:0] srNext;
    logic [CNT_W-1:0]  cntInc;
    logic [HIT_W-1:0]  hitInc;
    logic [MISS_W-1:0] missInc;

    // Two-flop synchronizers; the third sync flop only serves rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncPipe_q <= '0;
            dataPipe_q <= '0;
        end else begin
            syncPipe_q <= {syncPipe_q[1:0], bus.sync};
            dataPipe_q <= {dataPipe_q[0], bus.datain};
        end
    end

    assign bitEn     = syncPipe_q[1] & ~syncPipe_q[2];
    assign rxBit     = dataPipe_q[1];
    assign srNext    = {sr_q, rxBit};
    assign matchNorm = popCount(srNext ^ UW) <= ERR_LIM;
    assign window    = (cnt_q == LAST_CNT);
    assign cntInc    = window ? '0 : cnt_q + CNT_W'(1);
    assign hitInc    = hit_q + HIT_W'(1);
    assign missInc   = miss_q + MISS_W'(1);

`ifdef FRAME_SYNC_INV_DETECT_EN
    logic uwInv_q, uwInv_d, matchInv;

    assign matchInv  = popCount(srNext ^ ~UW) <= ERR_LIM;
    assign searchHit = matchNorm | matchInv;
    assign windowHit = uwInv_q ? matchInv : matchNorm;
    assign payBit    = rxBit ^ uwInv_q;
    assign bus.uw_inv = uwInv_q;
`else
    assign searchHit = matchNorm;
    assign windowHit = matchNorm;
    assign payBit    = rxBit;
    assign bus.uw_inv = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        byte_d       = byte_q;
        dout_d       = dout_q;
        doutVld_d    = 1'b0;
        frameStart_d = 1'b0;
`ifdef FRAME_SYNC_INV_DETECT_EN
        uwInv_d      = uwInv_q;
`endif
        if (bitEn) begin
            sr_d  = srNext[UW_LEN-2:0];
            cnt_d = cntInc;
            unique case (state_q)
                SEARCH: begin
                    if (searchHit) begin
`ifdef FRAME_SYNC_INV_DETECT_EN
                        uwInv_d = ~matchNorm;
`endif
                        cnt_d = '0;
                        hit_d = HIT_W'(1);
                        if (VERIFY_N <= 1) begin
                            state_d      = LOCK;
                            miss_d       = '0;
                            frameStart_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (window) begin
                        if (windowHit) begin
                            cnt_d = '0;
                            hit_d = hitInc;
                            if (hitInc == HIT_W'(VERIFY_N)) begin
                                state_d      = LOCK;
                                miss_d       = '0;
                                frameStart_d = 1'b1;
                            end
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
                LOCK: begin
                    // Flywheel: the window position is never re-aligned while locked.
                    if (window) begin
                        if (windowHit) begin
                            cnt_d        = '0;
                            miss_d       = '0;
                            frameStart_d = 1'b1;
                        end else if (missInc == MISS_W'(MISS_N)) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                            cnt_d   = '0;
                            byte_d  = '0;
                        end else begin
                            miss_d = missInc;
                        end
                    end else if (cntInc <= PAY_LAST) begin
                        byte_d = {byte_q[5:0], payBit};
                        if (cntInc[2:0] == 3'b000) begin
                            dout_d    = {byte_q, payBit};
                            doutVld_d = 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEARCH;
            sr_q         <= '0;
            cnt_q        <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            byte_q       <= '0;
            dout_q       <= '0;
            doutVld_q    <= 1'b0;
            frameStart_q <= 1'b0;
`ifdef FRAME_SYNC_INV_DETECT_EN
            uwInv_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            byte_q       <= byte_d;
            dout_q       <= dout_d;
            doutVld_q    <= doutVld_d;
            frameStart_q <= frameStart_d;
`ifdef FRAME_SYNC_INV_DETECT_EN
            uwInv_q      <= uwInv_d;
`endif
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_vld    = doutVld_q;
    assign bus.frame_start = frameStart_q;
    assign bus.state       = state_q;
    assign bus.locked      = (state_q == LOCK);
endmodule
